// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp constants and decode helpers for the
// two-road intersection sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        HW_GREEN    = 3'd0,
        HW_YELLOW   = 3'd1,
        ALLRED_A    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_B    = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2:0] hw_lamp(input state_t s);
        case (s)
            HW_GREEN:  return LAMP_G;
            HW_YELLOW: return LAMP_Y;
            default:   return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        case (s)
            SIDE_GREEN:  return LAMP_G;
            SIDE_YELLOW: return LAMP_Y;
            default:     return LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Seconds prescaler plus per-phase seconds counter; cleared whenever the
// sequencer changes phase, so every phase is timed from its own entry.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int SW            = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reload,
    input  logic [SW-1:0] dur,
    input  logic          hold_sat,
    output logic          done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler;
    logic [SW-1:0] sec_cnt;
    logic          sec_tick;
    logic          at_last;

    assign sec_tick = (prescaler == PS_MAX);
    assign at_last  = (sec_cnt == dur - SW'(1));
    assign done     = sec_tick && at_last;

    // In the hold phase the count parks on its last second, so done keeps
    // pulsing once per second while the prescaler free-runs.
    always_ff @(posedge clk) begin
        if (!reset || reload) begin
            prescaler <= '0;
            sec_cnt   <= '0;
        end else begin
            prescaler <= sec_tick ? '0 : prescaler + PW'(1);
            if (sec_tick && !(hold_sat && at_last))
                sec_cnt <= sec_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Highway / side-road phase sequencer: next-state logic, pedestrian latch and
// registered lamp decode, timed by a shared phase_timer.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 100_000_000,
    parameter int HW_GREEN_SEC   = 10,
    parameter int SIDE_GREEN_SEC = 5,
    parameter int YELLOW_SEC     = 3,
    parameter int ALLRED_SEC     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_side,
    input  logic       ped_req,
    output logic [2:0] hw_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int MAX_DUR = max2(max2(HW_GREEN_SEC, SIDE_GREEN_SEC),
                                  max2(YELLOW_SEC, ALLRED_SEC));
    localparam int SW = $clog2(MAX_DUR) + 1;

    state_t        state;
    state_t        nxt;
    logic [SW-1:0] dur;
    logic          done;
    logic          reload;
    logic          hold_sat;
    logic          entering_sg;
    logic          min_done;
    logic          ped_pend;
    logic          ped_served;
    logic          service_req;

    always_comb begin
        dur = SW'(ALLRED_SEC);
        case (state)
            HW_GREEN:                dur = SW'(HW_GREEN_SEC);
            HW_YELLOW, SIDE_YELLOW:  dur = SW'(YELLOW_SEC);
            SIDE_GREEN:              dur = SW'(SIDE_GREEN_SEC);
            default:                 dur = SW'(ALLRED_SEC);
        endcase
    end

    assign service_req = car_side || ped_pend || ped_req;

    always_comb begin
        nxt = state;
        case (state)
            HW_GREEN:    if ((min_done || done) && service_req) nxt = HW_YELLOW;
            HW_YELLOW:   if (done) nxt = ALLRED_A;
            ALLRED_A:    if (done) nxt = SIDE_GREEN;
            SIDE_GREEN:  if (done) nxt = SIDE_YELLOW;
            SIDE_YELLOW: if (done) nxt = ALLRED_B;
            ALLRED_B:    if (done) nxt = HW_GREEN;
            default:     nxt = ALLRED_A;
        endcase
    end

    assign reload      = (nxt != state);
    assign hold_sat    = (state == HW_GREEN);
    assign entering_sg = (nxt == SIDE_GREEN) && (state != SIDE_GREEN);

    phase_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .SW            (SW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .reload   (reload),
        .dur      (dur),
        .hold_sat (hold_sat),
        .done     (done)
    );

    // Outputs are decoded from the next state so they line up with the
    // state register and never depend combinationally on inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= HW_GREEN;
            min_done   <= 1'b0;
            ped_pend   <= 1'b0;
            ped_served <= 1'b0;
            hw_light   <= LAMP_G;
            side_light <= LAMP_R;
            walk       <= 1'b0;
            phase      <= 3'd0;
        end else begin
            state      <= nxt;
            phase      <= nxt;
            hw_light   <= hw_lamp(nxt);
            side_light <= side_lamp(nxt);
            min_done   <= reload ? 1'b0 : (min_done || (state == HW_GREEN && done));
            // A request on the entry edge itself is served, not left pending.
            if (entering_sg) begin
                ped_served <= ped_pend || ped_req;
                walk       <= ped_pend || ped_req;
                ped_pend   <= 1'b0;
            end else begin
                ped_served <= (nxt == SIDE_GREEN) && ped_served;
                walk       <= (nxt == SIDE_GREEN) && ped_served;
                ped_pend   <= ped_pend || ped_req;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with tiny timing parameters.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       car_side = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] hw_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] phase;
    logic [9:0] obs;

    int cyc = 0;
    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .TICKS_PER_SEC  (4),
        .HW_GREEN_SEC   (3),
        .SIDE_GREEN_SEC (3),
        .YELLOW_SEC     (2),
        .ALLRED_SEC     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .car_side   (car_side),
        .ped_req    (ped_req),
        .hw_light   (hw_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    assign obs = {phase, hw_light, side_light, walk};

    // Expected phase for a cycle started from HW_GREEN with service requested.
    function automatic int sched(input int c);
        int t;
        t = c % 48;
        if (t < 12) return 0;
        if (t < 20) return 1;
        if (t < 24) return 2;
        if (t < 36) return 3;
        if (t < 44) return 4;
        return 5;
    endfunction

    function automatic logic [9:0] exp_tuple(input int ph, input logic w);
        logic [2:0] hw;
        logic [2:0] sd;
        logic [2:0] p3;
        p3 = ph[2:0];
        hw = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
        sd = (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
        return {p3, hw, sd, w};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        ncomp++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        car_side = 1'b0;
        ped_req  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        // Reset state and long idle
        do_reset();
        check("rst_out", obs, exp_tuple(0, 1'b0));
        check("rst_latch", {dut.ped_pend, dut.ped_served}, 2'b00);
        repeat (200) begin
            step();
            check("idle", obs, exp_tuple(0, 1'b0));
        end

        // car_side held from cycle 0: full cycle with period 48
        do_reset();
        car_side = 1'b1;
        while (cyc <= 120) begin
            check("car_seq", obs, exp_tuple(sched(cyc), 1'b0));
            step();
        end

        // Late car arrival after HW_GREEN has idled past its minimum
        do_reset();
        run_to(30);
        check("late_pre", obs, exp_tuple(0, 1'b0));
        car_side = 1'b1;
        step();
        check("late_yield", obs, exp_tuple(1, 1'b0));
        car_side = 1'b0;
        while (cyc <= 75) begin
            check("late_seq", obs, exp_tuple(sched(cyc - 19), 1'b0));
            step();
        end

        // Single pedestrian pulse at cycle 5, no car
        do_reset();
        run_to(5);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("ped_pend_set", dut.ped_pend, 1'b1);
        while (cyc <= 100) begin
            check("ped_seq", obs,
                  exp_tuple((cyc < 48) ? sched(cyc) : 0, (cyc >= 24 && cyc <= 35)));
            if (cyc == 25) check("ped_pend_clr", dut.ped_pend, 1'b0);
            step();
        end

        // Pedestrian pulse exactly on the SIDE_GREEN entry cycle
        do_reset();
        car_side = 1'b1;
        run_to(12);
        car_side = 1'b0;
        run_to(23);
        check("entry_pre", obs, exp_tuple(2, 1'b0));
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("entry_latch", {dut.ped_pend, dut.ped_served}, 2'b01);
        while (cyc <= 100) begin
            check("entry_seq", obs,
                  exp_tuple((cyc < 48) ? sched(cyc) : 0, (cyc >= 24 && cyc <= 35)));
            step();
        end

        // Reset mid SIDE_GREEN with walk lit
        do_reset();
        car_side = 1'b1;
        run_to(5);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run_to(30);
        check("mid_pre", obs, exp_tuple(3, 1'b1));
        reset = 1'b0;
        step();
        check("mid_rst", obs, exp_tuple(0, 1'b0));
        check("mid_latch", {dut.ped_pend, dut.ped_served}, 2'b00);
        reset = 1'b1;
        cyc   = 0;
        while (cyc <= 24) begin
            check("mid_restart", obs, exp_tuple(sched(cyc), 1'b0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
